fir_decim_fifo: RTL

Downstream stage of the parallel symmetric FIR. Consumes the filter's valid-qualified signed 16-bit output stream and performs sum-and-dump decimation by a fixed power-of-two ratio, averaging each group of DECIM samples. Results are buffered in a small show-ahead FIFO and handed to the next consumer over a valid/ready handshake. A sticky overflow flag reports any result dropped because the FIFO was full.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_decim_fifo_if.sv | 25 ++
 rtl/fir_sync_fifo.sv | 60 ++++++
 rtl/fir_decim_fifo.sv | 92 +++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared FIR-chain definitions: default sample width, the signed sample type and a log2 helper.
// Latency: none. This file holds declarations only.
// Backpressure: none. This file holds declarations only.
package fir_pkg;

   localparam int DATA_W_DEF = 16;

   typedef logic signed [DATA_W_DEF-1:0] sample_t;

   // Shift amount for a power-of-two decimation ratio (S = log2(DECIM)).
   function automatic int decim_log2(input int d);
      int s;
      s = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < d) s = i + 1;
      end
      return s;
   endfunction

endpackage

// File: rtl/fir_decim_fifo_if.sv
// Bundles the sample-in / result-out handshake of the decimating output stage.
// Latency: none. The interface holds wires only.
// Backpressure: the master drives i_Ready and the slave drives o_Vld. The input side has no backpressure.
interface fir_decim_fifo_if #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic                     i_Vld;
   logic signed [DATA_W-1:0] i_Din;
   logic                     i_Sync;
   logic                     i_Ready;
   logic                     i_Ovf_Clr;
   logic                     o_Vld;
   logic signed [DATA_W-1:0] o_Dout;
   logic [LW-1:0]            o_Level;
   logic                     o_Ovf;

   // The master is the upstream FIR plus the downstream consumer. The slave is the decimator.
   modport master (output i_Vld, i_Din, i_Sync, i_Ready, i_Ovf_Clr,
                   input  o_Vld, o_Dout, o_Level, o_Ovf);
   modport slave  (input  i_Vld, i_Din, i_Sync, i_Ready, i_Ovf_Clr,
                   output o_Vld, o_Dout, o_Level, o_Ovf);
endinterface

// File: rtl/fir_sync_fifo.sv
// Show-ahead, count-based synchronous FIFO. The head word is presented combinationally and is forced to 0 when the FIFO is empty.
// Latency: a write is visible on o_Rdat one cycle after the write edge.
// Backpressure: a write into a full FIFO is dropped (o_Drop=1) unless a read frees a slot in the same cycle. A read when empty is ignored.
module fir_sync_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic          i_Clk,
   input  logic          i_Rst,
   input  logic          i_Wr,
   input  logic [W-1:0]  i_Wdat,
   input  logic          i_Rd,
   output logic [W-1:0]  o_Rdat,
   output logic          o_Vld,
   output logic          o_Drop,
   output logic [LW-1:0] o_Level
);
   logic [W-1:0]  r_Mem [DEPTH];
   logic [AW-1:0] r_Wp;
   logic [AW-1:0] r_Rp;
   logic [LW-1:0] r_Cnt;
   logic          w_Empty;
   logic          w_Full;
   logic          w_Rd;
   logic          w_Wr;

   assign w_Empty = (r_Cnt == '0);
   assign w_Full  = (r_Cnt == LW'(DEPTH));
   assign w_Rd    = i_Rd && !w_Empty;
   // A full FIFO still takes a write when the same cycle pops the head.
   assign w_Wr    = i_Wr && (!w_Full || w_Rd);
   assign o_Drop  = i_Wr && !w_Wr;
   assign o_Vld   = !w_Empty;
   assign o_Level = r_Cnt;
   assign o_Rdat  = w_Empty ? '0 : r_Mem[r_Rp];

   // Storage array. It has no reset because the count decides what is valid.
   always_ff @(posedge i_Clk) begin
      if (w_Wr) r_Mem[r_Wp] <= i_Wdat;
   end

   // Pointers wrap naturally because DEPTH is a power of two. The count tracks occupancy.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         r_Wp  <= '0;
         r_Rp  <= '0;
         r_Cnt <= '0;
      end else begin
         if (w_Wr) r_Wp <= r_Wp + 1'b1;
         if (w_Rd) r_Rp <= r_Rp + 1'b1;
         case ({w_Wr, w_Rd})
            2'b10:   r_Cnt <= r_Cnt + 1'b1;
            2'b01:   r_Cnt <= r_Cnt - 1'b1;
            default: r_Cnt <= r_Cnt;
         endcase
      end
   end
endmodule

// File: rtl/fir_decim_fifo.sv
// Sum-and-dump decimator by DECIM feeding a show-ahead result FIFO. A sticky overflow flag is set when a result is dropped.
// Latency: last sample of a group at edge N gives the result on o_Dout after edge N+1. Macro FIR_DECIM_ROUND_EN enables round-half-up.
// Backpressure: the input is never stalled. o_Vld/i_Ready drain the FIFO, and a result meeting a full FIFO is dropped.
module fir_decim_fifo
   import fir_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DECIM  = 4,
   parameter int DEPTH  = 8
) (
   input logic              i_Clk,
   input logic              i_Rst,
   fir_decim_fifo_if.slave  bus
);
   localparam int S  = decim_log2(DECIM);
   localparam int AW = DATA_W + S;
   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [S-1:0] PH_ONE  = S'(1);
   localparam logic [S-1:0] PH_LAST = S'(DECIM - 1);

   logic [S-1:0]             r_Ph;
   logic signed [AW-1:0]     r_Acc;
   logic signed [DATA_W-1:0] r_Res;
   logic                     r_ResVld;
   logic                     r_Ovf;
   logic signed [AW-1:0]     w_Din_X;
   logic signed [AW:0]       w_Sum;
   logic signed [AW:0]       w_Rnd;
   logic signed [DATA_W-1:0] w_Scaled;
   logic                     w_Drop;
   logic [DATA_W-1:0]        w_Rdat;
   logic                     w_FVld;
   logic [LW-1:0]            w_Level;

   assign w_Din_X = AW'(bus.i_Din);
   assign w_Sum   = (AW + 1)'(r_Acc) + (AW + 1)'(bus.i_Din);
`ifdef FIR_DECIM_ROUND_EN
   localparam logic signed [AW:0] RND = (AW + 1)'(DECIM / 2);
   assign w_Rnd = w_Sum + RND;
`else
   assign w_Rnd = w_Sum;
`endif
   // A full group of DATA_W-bit samples divided by DECIM always fits back into DATA_W bits.
   assign w_Scaled = DATA_W'(w_Rnd >>> S);

   // Phase tracking and accumulation. A dump produces a one-cycle result pulse, and sync restarts the group.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         r_Ph     <= '0;
         r_Acc    <= '0;
         r_Res    <= '0;
         r_ResVld <= 1'b0;
      end else begin
         r_ResVld <= 1'b0;
         if (bus.i_Sync) begin
            r_Ph <= bus.i_Vld ? PH_ONE : '0;
            if (bus.i_Vld) r_Acc <= w_Din_X;
         end else if (bus.i_Vld) begin
            r_Ph  <= r_Ph + PH_ONE;
            r_Acc <= (r_Ph == '0) ? w_Din_X : r_Acc + w_Din_X;
            if (r_Ph == PH_LAST) begin
               r_Res    <= w_Scaled;
               r_ResVld <= 1'b1;
            end
         end
      end
   end

   // Sticky overflow flag. A drop in the same cycle beats a clear.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst)           r_Ovf <= 1'b0;
      else if (w_Drop)      r_Ovf <= 1'b1;
      else if (bus.i_Ovf_Clr) r_Ovf <= 1'b0;
   end

   fir_sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_Wr    (r_ResVld),
      .i_Wdat  (r_Res),
      .i_Rd    (bus.i_Ready),
      .o_Rdat  (w_Rdat),
      .o_Vld   (w_FVld),
      .o_Drop  (w_Drop),
      .o_Level (w_Level)
   );

   assign bus.o_Vld   = w_FVld;
   assign bus.o_Dout  = w_Rdat;
   assign bus.o_Level = w_Level;
   assign bus.o_Ovf   = r_Ovf;
endmodule
